audio_bus_tx: RTL

//   Output-side counterpart of the input audio bus. Drains converted samples from the SRC output FIFO
//   (first-word-fall-through read port) at a fixed output sample rate derived from i_clk.

---
 rtl/audio_bus_pkg.sv | 16 +
 rtl/audio_tick_gen.sv | 41 ++++
 rtl/audio_bus_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/audio_bus_pkg.sv
// Purpose: shared types and constants for the output audio bus.
// Latency: n/a (types only).
// Backpressure: n/a.
package audio_bus_pkg;

    // Default sample width used when a parent does not override DATA_WIDTH.
    localparam int AUDIO_DATA_WIDTH = 32;

    // Playback FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } tx_state_t;

endpackage

// File: rtl/audio_tick_gen.sv
// Purpose: modulo-DIV counter producing one tick per DIV enabled cycles.
// Latency: tick is combinational from the count; the first tick comes DIV-1 cycles after a clear.
// Backpressure: none; free-running while enabled, held at zero while cleared.
module audio_tick_gen #(
    parameter int DIV = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick = i_en & (cnt_q == LAST);

    // Next count: clear dominates, otherwise wrap at DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_bus_tx.sv
// Purpose: drain a FWFT sample FIFO at one sample per DIV clocks, with prefill, underrun and resync.
// Latency: dout/newout update at the edge where rinc is high (registered copy of the read).
// Backpressure: none upstream; an empty FIFO at a tick is an underrun (silence, or sample-hold when
//   AUDIO_TX_HOLD_ON_UNDERRUN_EN is defined); RESYNC_AFTER consecutive underruns return to prefill.
module audio_bus_tx
    import audio_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = AUDIO_DATA_WIDTH,
    parameter int DIV          = 256,
    parameter int LVL_WIDTH    = 5,
    parameter int PREFILL      = 4,
    parameter int RESYNC_AFTER = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  rempty,
    input  logic [LVL_WIDTH-1:0]  rlevel,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  newout,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  o_underrun,
    output logic [CNT_WIDTH-1:0]  o_ucount
);

    localparam int CSW = $clog2(RESYNC_AFTER + 1);
    localparam logic [CSW-1:0]       RESYNC_LAST = CSW'(RESYNC_AFTER - 1);
    localparam logic [LVL_WIDTH-1:0] PREFILL_LVL = LVL_WIDTH'(PREFILL);

    tx_state_t             state_q,   state_d;
    logic [DATA_WIDTH-1:0] dout_q,    dout_d;
    logic                  newout_q,  newout_d;
    logic                  under_q,   under_d;
    logic [CNT_WIDTH-1:0]  ucount_q,  ucount_d;
    logic [CSW-1:0]        consec_q,  consec_d;

    logic in_run;
    logic tick;

    assign in_run = (state_q == ST_RUN);

    // Sample-period timer; held at zero outside RUN so RUN always starts a fresh period.
    audio_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (~in_run),
        .i_en   (in_run),
        .o_tick (tick)
    );

    // Read strobe is masked by disable and reset so an aborting cycle never pops a word.
    assign rinc = in_run & tick & i_en & ~rempty & ~i_rst;

    assign newout     = newout_q;
    assign dout       = dout_q;
    assign o_underrun = under_q;
    assign o_ucount   = ucount_q;

    // Next-state, output and statistics logic; disable has priority over any tick.
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        newout_d = 1'b0;
        under_d  = under_q;
        ucount_d = ucount_q;
        consec_d = consec_q;
        if (!i_en) begin
            state_d  = ST_IDLE;
            under_d  = 1'b0;
            ucount_d = '0;
            consec_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (rlevel >= PREFILL_LVL) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        newout_d = 1'b1;
                        if (!rempty) begin
                            dout_d   = rdata;
                            consec_d = '0;
                        end else begin
`ifdef AUDIO_TX_HOLD_ON_UNDERRUN_EN
                            dout_d = dout_q;
`else
                            dout_d = '0;
`endif
                            under_d = 1'b1;
                            if (ucount_q != {CNT_WIDTH{1'b1}}) begin
                                ucount_d = ucount_q + CNT_WIDTH'(1);
                            end
                            if (consec_q == RESYNC_LAST) begin
                                consec_d = '0;
                                state_d  = ST_PREFILL;
                            end else begin
                                consec_d = consec_q + CSW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            dout_q   <= '0;
            newout_q <= 1'b0;
            under_q  <= 1'b0;
            ucount_q <= '0;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            newout_q <= newout_d;
            under_q  <= under_d;
            ucount_q <= ucount_d;
            consec_q <= consec_d;
        end
    end

endmodule
